// File: rtl/rs232_rx_fifo.sv
// Receive-side byte FIFO behind the RS232 receiver: captures ReadLine on each DataReady
// pulse, presents the head byte first-word-fall-through, and flags dropped bytes as Overrun.
module rs232_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [7:0]        ReadLine,
    input  logic              DataReady,
    output logic [7:0]        ReadData,
    output logic              ReadValid,
    input  logic              ReadAck,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty,
    output logic              Overrun,
    input  logic              ClearOverrun
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;

    logic is_empty, is_full;
    logic do_pop, do_write, do_drop;

    // One extra pointer bit tells a full FIFO apart from an empty one.
    assign is_empty = (wr_ptr_q == rd_ptr_q);
    assign is_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // A pop in the same cycle frees the slot the incoming byte needs.
    assign do_pop   = ReadAck && !is_empty;
    assign do_write = DataReady && (!is_full || do_pop);
    assign do_drop  = DataReady && is_full && !do_pop;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (ClearOverrun) overrun_d = 1'b0;
        if (do_drop)      overrun_d = 1'b1;
    end

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge Clock) begin
        if (Reset_n && do_write) mem_q[wr_ptr_q[ADDR_W-1:0]] <= ReadLine;
    end

    assign ReadData  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign ReadValid = !is_empty;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Count     = wr_ptr_q - rd_ptr_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: a byte queue holds the expected FIFO contents and
// every cycle the DUT's occupancy, flags and head byte are checked against it.
module tb_rs232_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic [7:0]        ReadLine;
    logic              DataReady;
    logic [7:0]        ReadData;
    logic              ReadValid;
    logic              ReadAck;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Empty;
    logic              Overrun;
    logic              ClearOverrun;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    logic [7:0] sb[$];
    logic       m_ovr;

    rs232_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .ReadLine     (ReadLine),
        .DataReady    (DataReady),
        .ReadData     (ReadData),
        .ReadValid    (ReadValid),
        .ReadAck      (ReadAck),
        .Count        (Count),
        .Full         (Full),
        .Empty        (Empty),
        .Overrun      (Overrun),
        .ClearOverrun (ClearOverrun)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},   32'(Count),     32'(sb.size()));
        check({tag, ".empty"},   32'(Empty),     32'(sb.size() == 0));
        check({tag, ".valid"},   32'(ReadValid), 32'(sb.size() != 0));
        check({tag, ".full"},    32'(Full),      32'(sb.size() == DEPTH));
        check({tag, ".overrun"}, 32'(Overrun),   32'(m_ovr));
        if (sb.size() != 0) check({tag, ".head"}, 32'(ReadData), 32'(sb[0]));
    endtask

    // One clock of stimulus; the expected queue is updated from the same inputs.
    task automatic cycle(input string tag, input logic dr, input logic [7:0] d,
                         input logic ack, input logic clr);
        bit pop_ok, drop;
        pop_ok = ack && (sb.size() > 0);
        drop   = dr && (sb.size() == DEPTH) && !pop_ok;
        DataReady    = dr;
        ReadLine     = d;
        ReadAck      = ack;
        ClearOverrun = clr;
        @(posedge Clock);
        #1;
        if (pop_ok) void'(sb.pop_front());
        if (dr && !drop) sb.push_back(d);
        if (clr)  m_ovr = 1'b0;
        if (drop) m_ovr = 1'b1;
        DataReady    = 1'b0;
        ReadLine     = 8'h00;
        ReadAck      = 1'b0;
        ClearOverrun = 1'b0;
        check_state(tag);
    endtask

    initial begin
        Reset_n      = 1'b0;
        ReadLine     = 8'h00;
        DataReady    = 1'b0;
        ReadAck      = 1'b0;
        ClearOverrun = 1'b0;
        m_ovr        = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_state("reset");
        Reset_n = 1'b1;

        // Single byte: visible one cycle after the write, then popped.
        cycle("w41", 1'b1, 8'h41, 1'b0, 1'b0);
        check("w41.data", 32'(ReadData), 32'h41);
        cycle("pop41", 1'b0, 8'h00, 1'b1, 1'b0);

        // Order and pointer wrap.
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        check("fill.full", 32'(Full), 32'h1);
        repeat (8) cycle("pop8", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 16; i < 24; i++) cycle("wrap", 1'b1, 8'(i), 1'b0, 1'b0);
        repeat (16) cycle("drain1", 1'b0, 8'h00, 1'b1, 1'b0);

        // Overrun: drop when full, clear, and set-beats-clear.
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(i), 1'b0, 1'b0);
        cycle("dropAA", 1'b1, 8'hAA, 1'b0, 1'b0);
        check("dropAA.ovr", 32'(Overrun), 32'h1);
        cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("clr_drop", 1'b1, 8'hBB, 1'b0, 1'b1);
        check("clr_drop.ovr", 32'(Overrun), 32'h1);
        cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous write and pop: 0x55 accepted and read last.
        check("head00", 32'(ReadData), 32'h00);
        cycle("full_wp", 1'b1, 8'h55, 1'b1, 1'b0);
        repeat (15) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        check("last55", 32'(ReadData), 32'h55);
        cycle("pop55", 1'b0, 8'h00, 1'b1, 1'b0);

        // Empty corner cases.
        cycle("ack_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("w33_ack", 1'b1, 8'h33, 1'b1, 1'b0);
        check("w33.data", 32'(ReadData), 32'h33);

        // Reset mid-stream with Count=5 and Overrun=1.
        for (int i = 0; i < 15; i++) cycle("fill3", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle("drop3", 1'b1, 8'hEE, 1'b0, 1'b0);
        repeat (11) cycle("pop11", 1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst.count", 32'(Count), 32'd5);
        Reset_n   = 1'b0;
        DataReady = 1'b1;
        ReadLine  = 8'h99;
        ReadAck   = 1'b1;
        @(posedge Clock);
        #1;
        sb.delete();
        m_ovr     = 1'b0;
        Reset_n   = 1'b1;
        DataReady = 1'b0;
        ReadAck   = 1'b0;
        check_state("mid_rst");
        cycle("post_rst_w", 1'b1, 8'h77, 1'b0, 1'b0);
        check("post_rst.data", 32'(ReadData), 32'h77);
        cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
